ads_frame_reader: RTL and testbench
===================================

# ads_frame_reader

Reads one multi-channel sample frame from an ADS1299-class EEG ADC over SPI on each data-ready event. It sign-extends every 24-bit channel code into the Q2.29 32-bit format used by the preprocessor filter chain. The block sits at the head of the preprocessor and feeds the biquad filter stages one channel sample at a time with a valid strobe. It also exports the frame status word and flags frames it had to miss.

## Interface
Parameters:
- `N_CH`, 8: channels per frame, 1..8.
- `CLK_DIV`, 4: SCLK half-period in `clk` cycles, ≥2.
- `CODE_W`, 24: ADC code width, including the 24-bit status word; fixed.

Ports:
- `clk`, in, 1: system clock; all logic on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `enable`, in, 1: run enable. Low means abort and idle.
- `drdy_n`, in, 1: ADC data-ready, asynchronous, active-low.
- `spi_miso`, in, 1: ADC data out.
- `spi_sclk`, out, 1: SPI clock, mode 1 (CPOL=0, CPHA=1).
- `spi_cs_n`, out, 1: chip select, active-low.
- `sample_out`, out, 32: channel sample, signed Q2.29.
- `sample_ch`, out, 3: channel index of `sample_out`.
- `sample_valid`, out, 1: one-cycle strobe marking `sample_out` and `sample_ch` as valid.
- `status_out`, out, 24: frame status word.
- `status_valid`, out, 1: one-cycle strobe for `status_out`.
- `frame_done`, out, 1: one-cycle strobe after the last channel of a frame.
- `overrun`, out, 1: one-cycle strobe when a data-ready event arrives while a frame is in progress.

## Operation
- `drdy_n` passes through a 2-FF synchronizer, then a falling-edge detector, producing `drdy_evt`.
- Frame length is `FRAME_BITS = CODE_W*(N_CH+1)`, which is 216 at defaults. Bit order is status word first, then ch0..ch(N_CH-1), MSB first.
- FSM states:
  - IDLE: `cs_n`=1, `sclk`=0. Go to CS_SETUP on `drdy_evt && enable`.
  - CS_SETUP: `cs_n`=0 for `CLK_DIV` cycles, then go to SHIFT.
  - SHIFT: each bit takes 2·`CLK_DIV` cycles. `sclk`=1 for the first half and 0 for the second half. `spi_miso` is sampled in the cycle in which `sclk` falls (end of the high half), into a 24-bit shift register. After bit `FRAME_BITS-1`, go to CS_HOLD.
  - CS_HOLD: `cs_n`=0, `sclk`=0 for `CLK_DIV` cycles, then go to IDLE with `frame_done` pulsed.
- Word completion, on every 24th captured bit:
  - Word 0: load `status_out` and pulse `status_valid`.
  - Word k≥1: `sample_out = {code[23], code[23], code, 6'b0}`, `sample_ch = k-1`, pulse `sample_valid`. Full scale ±2^23 maps to ±1.0 in Q2.29.
- `overrun`: pulsed on `drdy_evt` in any state other than IDLE. The current frame continues unaffected, and the event is not queued.
- `enable` low in any state: go to IDLE next cycle with `cs_n`=1, `sclk`=0. No further strobes, no `frame_done`, and the bit counter clears. `sample_out`, `sample_ch` and `status_out` hold their last values.
- Simultaneous `drdy_evt` and `enable` rising: the frame starts; `enable` is sampled in the same cycle as the event.

## Timing
- Reset values:
  - `spi_cs_n`=1, `spi_sclk`=0.
  - `sample_out`=0, `sample_ch`=0, `status_out`=0.
  - All strobes 0; FSM in IDLE; synchronizer flops 1; counters 0.
- Synchronizer plus edge detector: `drdy_evt` rises 3 cycles after the `drdy_n` fall reaches the input. CS_SETUP is entered the cycle after `drdy_evt`.
- `sample_valid` or `status_valid` asserts 1 cycle after the sampling cycle of the word's last bit.
- Frame duration from `cs_n` low to `cs_n` high: `CLK_DIV*(2+2*FRAME_BITS)` cycles, which is 1736 at defaults. `frame_done` pulses in the cycle `cs_n` returns high.
- All outputs are registered. There is no back-pressure; downstream logic must accept every strobe.
- `rst` mid-frame: reset values take effect on the next edge.

## Structure
- `preproc_pkg`:
  - FSM state enum `frame_state_t`
  - `Q_FRAC`=29
  - function `code_to_q2_29(logic [23:0]) -> logic signed [31:0]`
  - constant expression for `FRAME_BITS`
- Sub-module `sync_fall_detect`: 2-FF synchronizer plus falling-edge pulse, reset value 1.
- One FSM plus three counters: clock-divider count, bit-in-word count (0..23), word count (0..N_CH).

## Test plan
- ADC model with `N_CH`=8, `CLK_DIV`=4. Status 0xC00000, ch0..ch7 = 0x000001, 0x7FFFFF, 0x800000, 0xFFFFFF, 0x123456, 0, 0x400000, 0xC00000. Required:
  - `status_valid` with 0xC00000.
  - Then `sample_out` 0x00000040, 0x1FFFFFC0, 0xE0000000, 0xFFFFFFC0, 0x048D1580, 0, 0x10000000, 0xF0000000 with `sample_ch` 0..7.
  - `frame_done` after ch7; `cs_n` low for exactly 1736 cycles.
- SCLK check: measure SCLK period (8 clk) and count falling edges per frame (216). Confirm each MISO bit is sampled only on a falling edge.
- Second `drdy_n` fall 500 cycles into a frame: `overrun` pulses once. The current frame completes with correct data, and no second frame starts.
- `enable` dropped after ch3 is emitted: `cs_n` high next cycle. No further `sample_valid`, no `frame_done`. The next `drdy_n` fall with `enable` high yields a full correct frame.
- `rst` asserted mid-SHIFT: all outputs at reset values next cycle, FSM in IDLE. A `drdy_n` held low through the release of `rst` does not start a frame until a new falling edge.
- `N_CH`=4 build: 120-bit frame, `sample_ch` 0..3, `frame_done` after ch3.

Source files
------------

// File: rtl/preproc_pkg.sv
// Shared types and helpers for the EEG preprocessor front end: frame FSM states
// and the 24-bit ADC code to Q2.29 conversion.
package preproc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD
    } frame_state_t;

    localparam int Q_FRAC     = 29;
    localparam int ADS_CODE_W = 24;

    // Bits per frame: status word plus one word per channel.
    function automatic int frame_bits(input int n_ch);
        return ADS_CODE_W * (n_ch + 1);
    endfunction

    // A 24-bit code is a fraction of 2^23; shifting it up to 29 fractional bits
    // and sign-extending gives +/-1.0 at full scale.
    function automatic logic signed [31:0] code_to_q2_29(input logic [23:0] code);
        return {{2{code[23]}}, code, {(Q_FRAC - 23){1'b0}}};
    endfunction

endpackage

// File: rtl/sync_fall_detect.sv
// Two-flop synchronizer for an asynchronous active-low strobe, followed by a
// registered one-cycle pulse on each synchronized falling edge.
module sync_fall_detect (
    input  logic clk,
    input  logic rst,
    input  logic din_n,
    output logic fall
);

    logic       s1_reg;
    logic       s2_reg;
    logic       s3_reg;
    logic       fall_reg;
    logic       armed_reg;
    logic [1:0] fill_reg;

    // The flops reset high, so an input already low at reset release would look
    // like a fresh edge; arm only after the synchronized input is seen high.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_reg    <= 1'b1;
            s2_reg    <= 1'b1;
            s3_reg    <= 1'b1;
            fall_reg  <= 1'b0;
            armed_reg <= 1'b0;
            fill_reg  <= 2'd0;
        end else begin
            s1_reg   <= din_n;
            s2_reg   <= s1_reg;
            s3_reg   <= s2_reg;
            fall_reg <= armed_reg && s3_reg && !s2_reg;
            if (fill_reg != 2'd2) begin
                fill_reg <= fill_reg + 2'd1;
            end
            if (fill_reg == 2'd2 && s2_reg) begin
                armed_reg <= 1'b1;
            end
        end
    end

    assign fall = fall_reg;

endmodule

// File: rtl/ads_frame_reader.sv
// Reads one status+channel frame from an ADS1299-class ADC per data-ready event
// over SPI mode 1 and streams the channels out as Q2.29 samples.
module ads_frame_reader
    import preproc_pkg::*;
#(
    parameter int N_CH    = 8,
    parameter int CLK_DIV = 4,
    parameter int CODE_W  = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               drdy_n,
    input  logic               spi_miso,
    output logic               spi_sclk,
    output logic               spi_cs_n,
    output logic signed [31:0] sample_out,
    output logic [2:0]         sample_ch,
    output logic               sample_valid,
    output logic [23:0]        status_out,
    output logic               status_valid,
    output logic               frame_done,
    output logic               overrun
);

    localparam int DIV_W  = $clog2(2 * CLK_DIV);
    localparam int WORD_W = 4;
    localparam logic [DIV_W-1:0]  HALF_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  BIT_END   = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [4:0]        BIT_LAST  = 5'(CODE_W - 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(N_CH);

    frame_state_t       state_reg, state_next;
    logic [DIV_W-1:0]   div_reg, div_next;
    logic [4:0]         bit_reg;
    logic [WORD_W-1:0]  word_reg;
    logic [22:0]        shift_reg;
    logic               drdy_evt;
    logic               sample_tick;
    logic               bit_end;
    logic [23:0]        word_in;

    logic               cs_n_reg, sclk_reg;
    logic signed [31:0] sample_reg;
    logic [2:0]         sample_ch_reg;
    logic [23:0]        status_reg;
    logic               sample_valid_reg, status_valid_reg, frame_done_reg, overrun_reg;

    sync_fall_detect u_drdy_sync (
        .clk   (clk),
        .rst   (rst),
        .din_n (drdy_n),
        .fall  (drdy_evt)
    );

    // MISO is captured on the last high cycle, i.e. as SCLK falls.
    assign sample_tick = (state_reg == SHIFT) && (div_reg == HALF_LAST) && enable;
    assign bit_end     = (state_reg == SHIFT) && (div_reg == BIT_END);
    assign word_in     = {shift_reg, spi_miso};

    always_comb begin
        state_next = state_reg;
        div_next   = div_reg + 1'b1;
        case (state_reg)
            IDLE: begin
                div_next = '0;
                if (drdy_evt && enable) begin
                    state_next = CS_SETUP;
                end
            end
            CS_SETUP: begin
                if (div_reg == HALF_LAST) begin
                    state_next = SHIFT;
                    div_next   = '0;
                end
            end
            SHIFT: begin
                if (div_reg == BIT_END) begin
                    div_next = '0;
                    if (bit_reg == BIT_LAST && word_reg == WORD_LAST) begin
                        state_next = CS_HOLD;
                    end
                end
            end
            CS_HOLD: begin
                if (div_reg == HALF_LAST) begin
                    state_next = IDLE;
                    div_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                div_next   = '0;
            end
        endcase
        if (!enable) begin
            state_next = IDLE;
            div_next   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            div_reg          <= '0;
            bit_reg          <= '0;
            word_reg         <= '0;
            shift_reg        <= '0;
            cs_n_reg         <= 1'b1;
            sclk_reg         <= 1'b0;
            sample_reg       <= '0;
            sample_ch_reg    <= '0;
            status_reg       <= '0;
            sample_valid_reg <= 1'b0;
            status_valid_reg <= 1'b0;
            frame_done_reg   <= 1'b0;
            overrun_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            div_reg          <= div_next;
            cs_n_reg         <= (state_next == IDLE);
            sclk_reg         <= (state_next == SHIFT) && (div_next <= HALF_LAST);
            sample_valid_reg <= 1'b0;
            status_valid_reg <= 1'b0;
            frame_done_reg   <= (state_reg == CS_HOLD) && (state_next == IDLE) && enable;
            overrun_reg      <= drdy_evt && (state_reg != IDLE);

            if (state_next != SHIFT) begin
                bit_reg  <= '0;
                word_reg <= '0;
            end else if (bit_end) begin
                if (bit_reg == BIT_LAST) begin
                    bit_reg  <= '0;
                    word_reg <= word_reg + 1'b1;
                end else begin
                    bit_reg <= bit_reg + 1'b1;
                end
            end

            if (sample_tick) begin
                shift_reg <= word_in[22:0];
                if (bit_reg == BIT_LAST) begin
                    if (word_reg == '0) begin
                        status_reg       <= word_in;
                        status_valid_reg <= 1'b1;
                    end else begin
                        sample_reg       <= code_to_q2_29(word_in);
                        sample_ch_reg    <= 3'(word_reg - 1'b1);
                        sample_valid_reg <= 1'b1;
                    end
                end
            end
        end
    end

    assign spi_cs_n     = cs_n_reg;
    assign spi_sclk     = sclk_reg;
    assign sample_out   = sample_reg;
    assign sample_ch    = sample_ch_reg;
    assign status_out   = status_reg;
    assign sample_valid = sample_valid_reg;
    assign status_valid = status_valid_reg;
    assign frame_done   = frame_done_reg;
    assign overrun      = overrun_reg;

endmodule

// File: tb/tb_ads_frame_reader.sv
// Bench for ads_frame_reader: an SPI ADC model feeds an 8-channel and a
// 4-channel instance; strobes are compared against a frame-level model.
module tb_ads_frame_reader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]        enable, drdy_n, miso, sclk, cs_n, sval, stval, done, ovr;
    logic [1:0][31:0]  sout;
    logic [1:0][2:0]   sch;
    logic [1:0][23:0]  stat;

    ads_frame_reader #(.N_CH(8), .CLK_DIV(4), .CODE_W(24)) dut8 (
        .clk(clk), .rst(rst), .enable(enable[0]), .drdy_n(drdy_n[0]), .spi_miso(miso[0]),
        .spi_sclk(sclk[0]), .spi_cs_n(cs_n[0]), .sample_out(sout[0]), .sample_ch(sch[0]),
        .sample_valid(sval[0]), .status_out(stat[0]), .status_valid(stval[0]),
        .frame_done(done[0]), .overrun(ovr[0])
    );

    ads_frame_reader #(.N_CH(4), .CLK_DIV(4), .CODE_W(24)) dut4 (
        .clk(clk), .rst(rst), .enable(enable[1]), .drdy_n(drdy_n[1]), .spi_miso(miso[1]),
        .spi_sclk(sclk[1]), .spi_cs_n(cs_n[1]), .sample_out(sout[1]), .sample_ch(sch[1]),
        .sample_valid(sval[1]), .status_out(stat[1]), .status_valid(stval[1]),
        .frame_done(done[1]), .overrun(ovr[1])
    );

    typedef struct {
        int          dut;
        int          kind;   // 0 status, 1 sample, 2 frame_done
        int          ch;
        logic [31:0] data;
    } ev_t;

    typedef struct {
        logic [23:0] code;
        logic [31:0] exp;
    } vec_t;

    ev_t         obs[$];
    logic [23:0] adc_w [2][9];
    int          ovr_cnt [2];
    int          low_cnt [2];
    int          fall_cnt [2];
    int          frames [2];
    int          bit_idx [2];
    int          per_bad [2];
    int          lat_bad [2];
    int          last_rise [2];
    int          cyc;
    logic [1:0]  sclk_p, cs_p;

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    // Reference conversion: code is a fraction of 2^23, output has 29 fractional bits.
    function automatic logic [31:0] q_model(input logic [23:0] code);
        int v;
        v = int'($signed(code));
        return 32'(v * (1 << (29 - 23)));
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ADC model and strobe monitor, evaluated 1 time unit after each clock edge.
    initial begin
        ev_t e;
        sclk_p = '0;
        cs_p   = '1;
        cyc    = 0;
        miso   = '0;
        for (int d = 0; d < 2; d++) begin
            ovr_cnt[d] = 0; low_cnt[d] = 0; fall_cnt[d] = 0; frames[d] = 0;
            bit_idx[d] = 0; per_bad[d] = 0; lat_bad[d] = 0; last_rise[d] = -1;
        end
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (cs_p[d] && !cs_n[d]) begin
                    low_cnt[d] = 0; fall_cnt[d] = 0; bit_idx[d] = 0; frames[d]++;
                    per_bad[d] = 0; lat_bad[d] = 0; last_rise[d] = -1;
                end
                if (!cs_n[d]) low_cnt[d]++;
                if (!sclk_p[d] && sclk[d]) begin
                    if (last_rise[d] >= 0 && (cyc - last_rise[d]) != 8) per_bad[d]++;
                    last_rise[d] = cyc;
                    // mode 1: ADC launches the next bit on the rising edge
                    if (bit_idx[d] < 24 * 9)
                        miso[d] = adc_w[d][bit_idx[d] / 24][23 - (bit_idx[d] % 24)];
                    bit_idx[d]++;
                end
                if (sclk_p[d] && !sclk[d]) fall_cnt[d]++;
                if ((sval[d] || stval[d]) !=
                    (sclk_p[d] && !sclk[d] && fall_cnt[d] > 0 && (fall_cnt[d] % 24) == 0))
                    lat_bad[d]++;
                if (done[d] && !(cs_n[d] && !cs_p[d])) lat_bad[d]++;
                if (stval[d]) begin
                    e.dut = d; e.kind = 0; e.ch = 0; e.data = {8'h00, stat[d]};
                    obs.push_back(e);
                end
                if (sval[d]) begin
                    e.dut = d; e.kind = 1; e.ch = int'(sch[d]); e.data = sout[d];
                    obs.push_back(e);
                end
                if (done[d]) begin
                    e.dut = d; e.kind = 2; e.ch = 0; e.data = 32'h0;
                    obs.push_back(e);
                end
                if (ovr[d]) ovr_cnt[d]++;
            end
            sclk_p = sclk;
            cs_p   = cs_n;
        end
    end

    task automatic wait_cs(input int d, input logic level, input int budget,
                           input string tag, output int n);
        n = 0;
        while (cs_n[d] !== level && n < budget) begin
            tick();
            n++;
        end
        if (cs_n[d] !== level) begin
            total++;
            bad++;
            $display("FAIL %s timeout: cs_n=%b want %b", tag, cs_n[d], level);
        end
    endtask

    task automatic check_frame(input int d, input int n, input logic [31:0] exp_d [9],
                               input string tag);
        ev_t e[$];
        foreach (obs[i]) if (obs[i].dut == d) e.push_back(obs[i]);
        chk({tag, " events"}, e.size(), n + 2);
        for (int k = 0; k < n + 2 && k < e.size(); k++) begin
            int          ek;
            int          ec;
            logic [31:0] ed;
            if (k == 0) begin
                ek = 0; ec = 0; ed = exp_d[0];
            end else if (k <= n) begin
                ek = 1; ec = k - 1; ed = exp_d[k];
            end else begin
                ek = 2; ec = 0; ed = 32'h0;
            end
            chk($sformatf("%s ev%0d kind", tag, k), e[k].kind, ek);
            chk($sformatf("%s ev%0d ch", tag, k), e[k].ch, ec);
            chk($sformatf("%s ev%0d data", tag, k), e[k].data, ed);
        end
    endtask

    // mode 0: plain frame, 1: second drdy fall 500 cycles in, 2: enable rises with the event
    task automatic do_frame(input int d, input int n, input logic [31:0] exp_d [9],
                            input int mode, input string tag);
        int lat;
        int f;
        obs.delete();
        ovr_cnt[d] = 0;
        if (mode == 2) begin
            enable[d] = 1'b0;
            tick();
        end
        drdy_n[d] = 1'b0;
        if (mode == 2) begin
            repeat (3) tick();
            enable[d] = 1'b1;
            tick();
            lat = 4;
        end else begin
            wait_cs(d, 1'b0, 20, tag, lat);
        end
        chk({tag, " start cs_n"}, cs_n[d], 0);
        chk({tag, " drdy latency"}, lat, 4);
        tick();
        drdy_n[d] = 1'b1;
        if (mode == 1) begin
            repeat (499) tick();
            drdy_n[d] = 1'b0;
        end
        wait_cs(d, 1'b1, 2500, tag, lat);
        repeat (3) tick();
        drdy_n[d] = 1'b1;
        check_frame(d, n, exp_d, tag);
        chk({tag, " cs_n low cycles"}, low_cnt[d], 4 * (2 + 2 * 24 * (n + 1)));
        chk({tag, " sclk falls"}, fall_cnt[d], 24 * (n + 1));
        chk({tag, " sclk period errs"}, per_bad[d], 0);
        chk({tag, " strobe timing errs"}, lat_bad[d], 0);
        chk({tag, " overrun pulses"}, ovr_cnt[d], (mode == 1) ? 1 : 0);
        if (mode == 1) begin
            f = frames[d];
            repeat (100) tick();
            chk({tag, " no second frame"}, frames[d] - f, 0);
        end
        repeat (5) tick();
    endtask

    task automatic rand_words(input int d, output logic [31:0] exp_d [9]);
        for (int i = 0; i < 9; i++) begin
            adc_w[d][i] = 24'($urandom);
            exp_d[i] = (i == 0) ? {8'h00, adc_w[d][0]} : q_model(adc_w[d][i]);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt [9];
        logic [31:0] ex [9];
        int          n;
        int          f;

        vt[0] = '{24'hC00000, 32'h00C00000};
        vt[1] = '{24'h000001, 32'h00000040};
        vt[2] = '{24'h7FFFFF, 32'h1FFFFFC0};
        vt[3] = '{24'h800000, 32'hE0000000};
        vt[4] = '{24'hFFFFFF, 32'hFFFFFFC0};
        vt[5] = '{24'h123456, 32'h048D1580};
        vt[6] = '{24'h000000, 32'h00000000};
        vt[7] = '{24'h400000, 32'h10000000};
        vt[8] = '{24'hC00000, 32'hF0000000};

        rst    = 1'b1;
        enable = '1;
        drdy_n = '1;
        repeat (3) tick();
        chk("reset cs_n", cs_n[0], 1);
        chk("reset sclk", sclk[0], 0);
        chk("reset sample_out", sout[0], 0);
        chk("reset status_out", stat[0], 0);
        chk("reset strobes", {sval[0], stval[0], done[0], ovr[0]}, 0);
        rst = 1'b0;
        repeat (6) tick();

        // Directed frame from the vector table
        for (int i = 0; i < 9; i++) begin
            adc_w[0][i] = vt[i].code;
            ex[i]       = vt[i].exp;
        end
        do_frame(0, 8, ex, 0, "directed");

        for (int r = 0; r < 3; r++) begin
            rand_words(0, ex);
            do_frame(0, 8, ex, 0, $sformatf("random%0d", r));
        end

        rand_words(0, ex);
        do_frame(0, 8, ex, 1, "overrun");

        // Abort by enable after ch3
        rand_words(0, ex);
        obs.delete();
        drdy_n[0] = 1'b0;
        wait_cs(0, 1'b0, 20, "abort", n);
        tick();
        drdy_n[0] = 1'b1;
        n = 0;
        while (obs.size() < 5 && n < 2500) begin
            tick();
            n++;
        end
        chk("abort reached ch3", obs.size(), 5);
        chk("abort last ch", obs[4].ch, 3);
        enable[0] = 1'b0;
        tick();
        chk("abort cs_n", cs_n[0], 1);
        chk("abort sclk", sclk[0], 0);
        repeat (2000) tick();
        chk("abort no more strobes", obs.size(), 5);
        chk("abort sample held", sout[0], q_model(adc_w[0][4]));
        chk("abort status held", stat[0], adc_w[0][0]);
        enable[0] = 1'b1;
        repeat (3) tick();
        rand_words(0, ex);
        do_frame(0, 8, ex, 0, "after_abort");

        // Reset in the middle of SHIFT with drdy_n held low through release
        rand_words(0, ex);
        drdy_n[0] = 1'b0;
        wait_cs(0, 1'b0, 20, "midrst", n);
        repeat (300) tick();
        rst = 1'b1;
        tick();
        chk("midrst cs_n", cs_n[0], 1);
        chk("midrst sclk", sclk[0], 0);
        chk("midrst sample_out", sout[0], 0);
        chk("midrst sample_ch", sch[0], 0);
        chk("midrst status_out", stat[0], 0);
        chk("midrst strobes", {sval[0], stval[0], done[0], ovr[0]}, 0);
        repeat (2) tick();
        rst = 1'b0;
        f = frames[0];
        repeat (60) tick();
        chk("midrst no restart", frames[0] - f, 0);
        chk("midrst idle cs_n", cs_n[0], 1);
        drdy_n[0] = 1'b1;
        repeat (6) tick();
        rand_words(0, ex);
        do_frame(0, 8, ex, 0, "after_rst");

        // Four-channel build
        for (int i = 0; i < 9; i++) begin
            adc_w[1][i] = (i < 5) ? vt[i].code : 24'h0;
            ex[i]       = vt[i].exp;
        end
        do_frame(1, 4, ex, 0, "n4_directed");
        rand_words(1, ex);
        do_frame(1, 4, ex, 2, "n4_enable_with_evt");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
